// File: rtl/rob_pkg.sv
// Shared constants, entry type and decode helpers for the reorder buffer.
package rob_pkg;

  localparam int unsigned ISSUE_WIDTH_MAX = 2;
  localparam int unsigned ROB_MAX_RETIRE  = 2;
  localparam int unsigned ROB_SIZE        = 32;
  localparam int unsigned ROB_SIZE_CLOG   = 5;
  localparam int unsigned NUM_CDB         = 2;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned OPCODE_LEN      = 7;
  localparam int unsigned SRC_LEN         = 5;

  localparam logic [OPCODE_LEN-1:0] S_TYPE  = 7'b0100011;
  localparam logic [OPCODE_LEN-1:0] SB_TYPE = 7'b1100011;

  typedef logic [ROB_SIZE_CLOG-1:0]                   rob_id_t;
  typedef logic [ROB_SIZE_CLOG:0]                     rob_cnt_t;
  typedef logic [$clog2(ISSUE_WIDTH_MAX+1)-1:0]       alloc_cnt_t;
  typedef logic [$clog2(ROB_MAX_RETIRE+1)-1:0]        ret_cnt_t;
  typedef logic [$clog2(ROB_MAX_RETIRE)-1:0]          ret_idx_t;

  typedef struct packed {
    logic               valid;
    logic               done;
    logic               has_rd;
    logic               is_br;
    logic               mispred;
    logic [SRC_LEN-1:0] rd;
    logic [XLEN-1:0]    data;
  } rob_entry_t;

  // Stores and branches never write a register; neither does x0.
  function automatic logic op_writes_rd(input logic [OPCODE_LEN-1:0] op,
                                        input logic [SRC_LEN-1:0]    rd);
    return (op != S_TYPE) && (op != SB_TYPE) && (rd != '0);
  endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Picks the in-order run of retirable entries at the head of the ROB and flags a
// mispredicted branch that ends the run.
module rob_retire_sel
  import rob_pkg::*;
(
  input  logic [ROB_MAX_RETIRE-1:0] valid_i,
  input  logic [ROB_MAX_RETIRE-1:0] done_i,
  input  logic [ROB_MAX_RETIRE-1:0] br_mis_i,
  input  rob_cnt_t                  count_i,
  output logic [ROB_MAX_RETIRE-1:0] ret_mask_o,
  output ret_cnt_t                  nret_o,
  output logic                      flush_o,
  output ret_idx_t                  flush_slot_o
);

  logic go;

  always_comb begin
    ret_mask_o   = '0;
    nret_o       = '0;
    flush_o      = 1'b0;
    flush_slot_o = '0;
    go           = 1'b1;
    for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
      if (go && valid_i[k] && done_i[k] && (rob_cnt_t'(k) < count_i)) begin
        ret_mask_o[k] = 1'b1;
        nret_o        = nret_o + ret_cnt_t'(1);
        // A mispredicted branch retires itself but blocks everything younger.
        if (br_mis_i[k]) begin
          flush_o      = 1'b1;
          flush_slot_o = ret_idx_t'(k);
          go           = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order id allocation, CDB completion capture, in-order retire
// of up to ROB_MAX_RETIRE entries per cycle and retire-time mispredict flush.
module rob
  import rob_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ISSUE_WIDTH_MAX-1:0]           instr_val_id,
  input  logic [ISSUE_WIDTH_MAX*OPCODE_LEN-1:0] opcode_id,
  input  logic [ISSUE_WIDTH_MAX*SRC_LEN-1:0]   rd_id,
  input  logic [NUM_CDB-1:0]                   cdb_val,
  input  logic [NUM_CDB*ROB_SIZE_CLOG-1:0]     cdb_robid,
  input  logic [NUM_CDB*XLEN-1:0]              cdb_data,
  input  logic [NUM_CDB-1:0]                   cdb_mispred,
  output logic [ROB_SIZE_CLOG-1:0]             rob_is_ptr,
  output logic [ROB_SIZE_CLOG-1:0]             rob_is_ptr_p1,
  output logic                                 rob_full,
  output logic [ROB_MAX_RETIRE*SRC_LEN-1:0]    rd_ret,
  output logic [ROB_MAX_RETIRE*XLEN-1:0]       data_ret,
  output logic [ROB_MAX_RETIRE-1:0]            val_ret,
  output logic [ROB_MAX_RETIRE-1:0]            branch_ret,
  output logic                                 branch_clear_id,
  output logic [ROB_SIZE_CLOG-1:0]             mispredict_tag_id
);

  rob_entry_t entry_q [ROB_SIZE];
  rob_entry_t entry_d [ROB_SIZE];

  rob_id_t  head_q, head_d;
  rob_id_t  tail_q, tail_d;
  rob_cnt_t count_q, count_d;

  logic [ROB_MAX_RETIRE*SRC_LEN-1:0] rd_ret_q, rd_ret_d;
  logic [ROB_MAX_RETIRE*XLEN-1:0]    data_ret_q, data_ret_d;
  logic [ROB_MAX_RETIRE-1:0]         val_ret_q, val_ret_d;
  logic [ROB_MAX_RETIRE-1:0]         branch_ret_q, branch_ret_d;
  logic                              branch_clear_q, branch_clear_d;
  rob_id_t                           mis_tag_q, mis_tag_d;

  rob_id_t                   win_idx [ROB_MAX_RETIRE];
  logic [ROB_MAX_RETIRE-1:0] win_valid, win_done, win_br_mis;
  logic [ROB_MAX_RETIRE-1:0] ret_mask;
  ret_cnt_t                  nret;
  logic                      flush;
  ret_idx_t                  flush_slot;
  rob_id_t                   flush_id;

  logic       alloc_en;
  alloc_cnt_t nalloc;
  rob_id_t    alloc_idx;
  rob_id_t    cdb_id;

  assign rob_is_ptr    = tail_q;
  assign rob_is_ptr_p1 = tail_q + rob_id_t'(1);
  assign rob_full      = count_q > rob_cnt_t'(ROB_SIZE - ISSUE_WIDTH_MAX);

  // Allocations landing on a flush edge belong to the wrong path.
  assign alloc_en = ~rob_full & ~flush;
  assign flush_id = head_q + rob_id_t'(flush_slot);

  always_comb begin
    for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
      win_idx[k]    = head_q + rob_id_t'(k);
      win_valid[k]  = entry_q[win_idx[k]].valid;
      win_done[k]   = entry_q[win_idx[k]].done;
      win_br_mis[k] = entry_q[win_idx[k]].is_br & entry_q[win_idx[k]].mispred;
    end
  end

  rob_retire_sel u_retire_sel (
    .valid_i      (win_valid),
    .done_i       (win_done),
    .br_mis_i     (win_br_mis),
    .count_i      (count_q),
    .ret_mask_o   (ret_mask),
    .nret_o       (nret),
    .flush_o      (flush),
    .flush_slot_o (flush_slot)
  );

  always_comb begin
    nalloc = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      nalloc = nalloc + alloc_cnt_t'(instr_val_id[i]);
    end
    if (!alloc_en) begin
      nalloc = '0;
    end
  end

  always_comb begin
    entry_d   = entry_q;
    cdb_id    = '0;
    alloc_idx = tail_q;
    // Later ports overwrite earlier ones, so the highest port wins on a tie.
    for (int p = 0; p < NUM_CDB; p++) begin
      cdb_id = cdb_robid[p*ROB_SIZE_CLOG +: ROB_SIZE_CLOG];
      if (cdb_val[p] && entry_q[cdb_id].valid) begin
        entry_d[cdb_id].done    = 1'b1;
        entry_d[cdb_id].data    = cdb_data[p*XLEN +: XLEN];
        entry_d[cdb_id].mispred = cdb_mispred[p];
      end
    end
    for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
      if (ret_mask[k]) begin
        entry_d[win_idx[k]].valid = 1'b0;
      end
    end
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      if (alloc_en && instr_val_id[i]) begin
        entry_d[alloc_idx] = '{
          valid:   1'b1,
          done:    1'b0,
          has_rd:  op_writes_rd(opcode_id[i*OPCODE_LEN +: OPCODE_LEN],
                                rd_id[i*SRC_LEN +: SRC_LEN]),
          is_br:   opcode_id[i*OPCODE_LEN +: OPCODE_LEN] == SB_TYPE,
          mispred: 1'b0,
          rd:      rd_id[i*SRC_LEN +: SRC_LEN],
          data:    '0
        };
        alloc_idx = alloc_idx + rob_id_t'(1);
      end
    end
    if (flush) begin
      for (int e = 0; e < ROB_SIZE; e++) begin
        entry_d[e].valid = 1'b0;
      end
    end
  end

  always_comb begin
    head_d  = head_q + rob_id_t'(nret);
    tail_d  = tail_q + rob_id_t'(nalloc);
    count_d = count_q + rob_cnt_t'(nalloc) - rob_cnt_t'(nret);
    if (flush) begin
      head_d  = flush_id + rob_id_t'(1);
      tail_d  = flush_id + rob_id_t'(1);
      count_d = '0;
    end
  end

  always_comb begin
    rd_ret_d       = '0;
    data_ret_d     = '0;
    val_ret_d      = ret_mask;
    branch_ret_d   = '0;
    branch_clear_d = flush;
    mis_tag_d      = flush ? flush_id : '0;
    for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
      if (ret_mask[k]) begin
        rd_ret_d[k*SRC_LEN +: SRC_LEN] = entry_q[win_idx[k]].rd;
        data_ret_d[k*XLEN +: XLEN]     = entry_q[win_idx[k]].data;
        branch_ret_d[k]                = ~entry_q[win_idx[k]].has_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      rd_ret_q       <= '0;
      data_ret_q     <= '0;
      val_ret_q      <= '0;
      branch_ret_q   <= '0;
      branch_clear_q <= 1'b0;
      mis_tag_q      <= '0;
      for (int e = 0; e < ROB_SIZE; e++) begin
        entry_q[e] <= '0;
      end
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      rd_ret_q       <= rd_ret_d;
      data_ret_q     <= data_ret_d;
      val_ret_q      <= val_ret_d;
      branch_ret_q   <= branch_ret_d;
      branch_clear_q <= branch_clear_d;
      mis_tag_q      <= mis_tag_d;
      entry_q        <= entry_d;
    end
  end

  assign rd_ret            = rd_ret_q;
  assign data_ret          = data_ret_q;
  assign val_ret           = val_ret_q;
  assign branch_ret        = branch_ret_q;
  assign branch_clear_id   = branch_clear_q;
  assign mispredict_tag_id = mis_tag_q;

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: allocation order, out-of-order completion, full/wrap
// boundaries, mispredict flush and asynchronous reset, with a retire scoreboard.
module tb_rob;
  import rob_pkg::*;

  localparam logic [OPCODE_LEN-1:0] ALU = 7'b0110011;

  logic                                  clk, rst;
  logic [ISSUE_WIDTH_MAX-1:0]            instr_val_id;
  logic [ISSUE_WIDTH_MAX*OPCODE_LEN-1:0] opcode_id;
  logic [ISSUE_WIDTH_MAX*SRC_LEN-1:0]    rd_id;
  logic [NUM_CDB-1:0]                    cdb_val, cdb_mispred;
  logic [NUM_CDB*ROB_SIZE_CLOG-1:0]      cdb_robid;
  logic [NUM_CDB*XLEN-1:0]               cdb_data;
  logic [ROB_SIZE_CLOG-1:0]              rob_is_ptr, rob_is_ptr_p1, mispredict_tag_id;
  logic                                  rob_full, branch_clear_id;
  logic [ROB_MAX_RETIRE*SRC_LEN-1:0]     rd_ret;
  logic [ROB_MAX_RETIRE*XLEN-1:0]        data_ret;
  logic [ROB_MAX_RETIRE-1:0]             val_ret, branch_ret;

  rob dut (
    .clk               (clk),
    .rst               (rst),
    .instr_val_id      (instr_val_id),
    .opcode_id         (opcode_id),
    .rd_id             (rd_id),
    .cdb_val           (cdb_val),
    .cdb_robid         (cdb_robid),
    .cdb_data          (cdb_data),
    .cdb_mispred       (cdb_mispred),
    .rob_is_ptr        (rob_is_ptr),
    .rob_is_ptr_p1     (rob_is_ptr_p1),
    .rob_full          (rob_full),
    .rd_ret            (rd_ret),
    .data_ret          (data_ret),
    .val_ret           (val_ret),
    .branch_ret        (branch_ret),
    .branch_clear_id   (branch_clear_id),
    .mispredict_tag_id (mispredict_tag_id)
  );

  typedef struct {
    logic [SRC_LEN-1:0] rd;
    logic [XLEN-1:0]    data;
    logic               br;
  } exp_t;

  exp_t             sb[$];
  rob_id_t          pend[$];
  exp_t             mon_e;
  logic [XLEN-1:0]  m_data [ROB_SIZE];
  rob_id_t          m_tail;
  int               n_checks, n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Retire monitor: every valid retire slot must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
        if (val_ret[k]) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
          end else begin
            mon_e = sb.pop_front();
            chk("ret_rd", 64'(rd_ret[k*SRC_LEN +: SRC_LEN]), 64'(mon_e.rd));
            chk("ret_data", 64'(data_ret[k*XLEN +: XLEN]), 64'(mon_e.data));
            chk("ret_br", 64'(branch_ret[k]), 64'(mon_e.br));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic v0, input logic [OPCODE_LEN-1:0] op0,
                       input logic [SRC_LEN-1:0] rd0, input logic v1,
                       input logic [OPCODE_LEN-1:0] op1, input logic [SRC_LEN-1:0] rd1,
                       input bit push);
    rob_id_t id;
    logic [OPCODE_LEN-1:0] op [2];
    logic [SRC_LEN-1:0]    rd [2];
    logic                  v  [2];
    exp_t                  e;
    op[0] = op0; op[1] = op1; rd[0] = rd0; rd[1] = rd1; v[0] = v0; v[1] = v1;
    instr_val_id = {v1, v0};
    opcode_id    = {op1, op0};
    rd_id        = {rd1, rd0};
    if (push) begin
      id = m_tail;
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          m_data[id] = $urandom;
          e.rd   = rd[i];
          e.data = m_data[id];
          e.br   = (op[i] == S_TYPE) || (op[i] == SB_TYPE) || (rd[i] == '0);
          sb.push_back(e);
          pend.push_back(id);
          id = id + rob_id_t'(1);
        end
      end
      m_tail = id;
    end
    @(posedge clk);
    #1;
    instr_val_id = '0;
  endtask

  task automatic cdb_drive(input logic v0, input rob_id_t id0, input logic m0,
                           input logic [XLEN-1:0] d0, input logic v1, input rob_id_t id1,
                           input logic m1, input logic [XLEN-1:0] d1);
    cdb_val = {v1, v0}; cdb_robid = {id1, id0}; cdb_mispred = {m1, m0}; cdb_data = {d1, d0};
    @(posedge clk);
    #1;
    cdb_val = '0; cdb_mispred = '0;
  endtask

  task automatic cdb1(input rob_id_t id, input logic mis);
    cdb_drive(1'b1, id, mis, m_data[id], 1'b0, '0, 1'b0, '0);
  endtask

  task automatic cdb2(input rob_id_t a, input rob_id_t b);
    cdb_drive(1'b1, a, 1'b0, m_data[a], 1'b1, b, 1'b0, m_data[b]);
  endtask

  task automatic complete_pend();
    rob_id_t a, b;
    while (pend.size() > 0) begin
      if (pend.size() >= 2) begin
        a = pend.pop_front();
        b = pend.pop_front();
        cdb2(a, b);
      end else begin
        a = pend.pop_front();
        cdb1(a, 1'b0);
      end
    end
    idle(3);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; m_tail = '0;
    instr_val_id = '0; opcode_id = '0; rd_id = '0;
    cdb_val = '0; cdb_robid = '0; cdb_data = '0; cdb_mispred = '0;
    rst = 1'b1;
    #12;
    chk("rst_ptr", 64'(rob_is_ptr), 64'd0);
    chk("rst_ptr_p1", 64'(rob_is_ptr_p1), 64'd1);
    chk("rst_full", 64'(rob_full), 64'd0);
    chk("rst_val_ret", 64'(val_ret), 64'd0);
    chk("rst_clear", 64'(branch_clear_id), 64'd0);
    rst = 1'b0;

    // Out-of-order completion: nothing retires until the oldest is done.
    alloc(1'b1, ALU, 5'd3, 1'b1, ALU, 5'd4, 1'b1);
    @(negedge clk);
    chk("dual_ptr", 64'(rob_is_ptr), 64'd2);
    chk("dual_ptr_p1", 64'(rob_is_ptr_p1), 64'd3);
    pend.delete();
    cdb1(5'd1, 1'b0);
    @(negedge clk); chk("ooo_hold0", 64'(val_ret), 64'd0);
    @(negedge clk); chk("ooo_hold1", 64'(val_ret), 64'd0);
    cdb1(5'd0, 1'b0);
    @(negedge clk); chk("ooo_lat", 64'(val_ret), 64'd0);
    @(negedge clk);
    chk("ooo_val", 64'(val_ret), 64'b11);
    chk("ooo_rd", 64'(rd_ret), 64'({5'd4, 5'd3}));
    @(negedge clk); chk("ooo_pulse", 64'(val_ret), 64'd0);

    // Fill to 32 entries; full asserts once fewer than two slots remain.
    for (int i = 0; i < 16; i++) begin
      alloc(1'b1, ALU, 5'(i + 1), 1'b1, ALU, 5'(i + 17), 1'b1);
      if (i == 14) chk("full_at_30", 64'(rob_full), 64'd0);
    end
    chk("full_at_32", 64'(rob_full), 64'd1);
    alloc(1'b1, ALU, 5'd9, 1'b1, ALU, 5'd10, 1'b0);
    alloc(1'b1, ALU, 5'd9, 1'b0, ALU, 5'd10, 1'b0);
    chk("full_ptr_held", 64'(rob_is_ptr), 64'(m_tail));
    cdb1(pend.pop_front(), 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("full_ret1", 64'(val_ret), 64'b01);
    chk("full_at_31", 64'(rob_full), 64'd1);
    complete_pend();
    chk("drained_full", 64'(rob_full), 64'd0);

    // Walk the pointers up to 31 for the wrap case.
    while (m_tail != 5'd31) begin
      if (5'd31 - m_tail >= 5'd2) alloc(1'b1, ALU, 5'd5, 1'b1, ALU, 5'd6, 1'b1);
      else                        alloc(1'b1, ALU, 5'd7, 1'b0, ALU, 5'd0, 1'b1);
      complete_pend();
    end
    alloc(1'b1, ALU, 5'd20, 1'b1, ALU, 5'd21, 1'b1);
    chk("wrap_ptr", 64'(rob_is_ptr), 64'd1);
    pend.delete();
    cdb1(5'd0, 1'b0);
    @(negedge clk); chk("wrap_hold0", 64'(val_ret), 64'd0);
    @(negedge clk); chk("wrap_hold1", 64'(val_ret), 64'd0);
    cdb1(5'd31, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_val", 64'(val_ret), 64'b11);
    chk("wrap_rd", 64'(rd_ret), 64'({5'd21, 5'd20}));
    idle(2);

    // Mispredicted branch at id 5 with younger done ALU ops at 6 and 7.
    alloc(1'b1, ALU, 5'd1, 1'b1, ALU, 5'd2, 1'b1);
    alloc(1'b1, ALU, 5'd3, 1'b1, ALU, 5'd4, 1'b1);
    complete_pend();
    alloc(1'b1, SB_TYPE, 5'd7, 1'b1, ALU, 5'd10, 1'b1);
    alloc(1'b1, ALU, 5'd11, 1'b0, ALU, 5'd0, 1'b1);
    pend.delete();
    cdb2(5'd6, 5'd7);
    @(negedge clk); chk("mis_hold", 64'(val_ret), 64'd0);
    cdb1(5'd5, 1'b1);
    alloc(1'b1, ALU, 5'd12, 1'b1, ALU, 5'd13, 1'b0);
    @(negedge clk);
    chk("mis_val", 64'(val_ret), 64'b01);
    chk("mis_clear", 64'(branch_clear_id), 64'd1);
    chk("mis_tag", 64'(mispredict_tag_id), 64'd5);
    chk("mis_ptr", 64'(rob_is_ptr), 64'd6);
    chk("mis_full", 64'(rob_full), 64'd0);
    #1;
    void'(sb.pop_back());
    void'(sb.pop_back());
    m_tail = 5'd6;
    @(negedge clk);
    chk("mis_clear_pulse", 64'(branch_clear_id), 64'd0);
    chk("mis_val_after", 64'(val_ret), 64'd0);

    // Same id on both CDB ports: port 1 data must be the one retired.
    alloc(1'b1, ALU, 5'd9, 1'b0, ALU, 5'd0, 1'b1);
    pend.delete();
    cdb_drive(1'b1, 5'd6, 1'b0, ~m_data[6], 1'b1, 5'd6, 1'b0, m_data[6]);
    idle(3);

    // Completion aimed at an empty entry is dropped.
    cdb1(5'd7, 1'b0);
    alloc(1'b1, ALU, 5'd12, 1'b0, ALU, 5'd0, 1'b1);
    pend.delete();
    @(negedge clk); chk("drop_hold0", 64'(val_ret), 64'd0);
    @(negedge clk); chk("drop_hold1", 64'(val_ret), 64'd0);
    cdb1(5'd7, 1'b0);
    idle(3);

    // Asynchronous reset with ten live entries and a retire pending.
    for (int i = 0; i < 5; i++) alloc(1'b1, ALU, 5'(i + 13), 1'b1, ALU, 5'(i + 23), 1'b1);
    chk("pre_rst_ptr", 64'(rob_is_ptr), 64'd18);
    cdb2(5'd8, 5'd9);
    #2 rst = 1'b1;
    #1;
    chk("arst_ptr", 64'(rob_is_ptr), 64'd0);
    chk("arst_ptr_p1", 64'(rob_is_ptr_p1), 64'd1);
    chk("arst_full", 64'(rob_full), 64'd0);
    chk("arst_val", 64'(val_ret), 64'd0);
    sb.delete();
    pend.delete();
    m_tail = '0;
    idle(2);
    chk("arst_val_held", 64'(val_ret), 64'd0);
    rst = 1'b0;
    alloc(1'b1, ALU, 5'd1, 1'b1, S_TYPE, 5'd2, 1'b1);
    chk("post_rst_ptr", 64'(rob_is_ptr), 64'd2);
    complete_pend();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
